// File: rtl/restador_serial_8bits.sv
// Bit-serial 8-bit subtractor: Resta = A - B - Bin, one bit per clock, LSB first.
// Optional macro RESTA_SAT_EN: on final borrow the result saturates to 0x00 (Bout still 1).
module restador_serial_8bits (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] Resta,
    output logic       Bout,
    output logic       Zero,
    output logic       state_dbg
);

    // Handshake: start is taken on any edge where busy=0 (IDLE, including the
    // done cycle); busy stays high for exactly 8 cycles, then done pulses once
    // with Resta/Bout/Zero valid. start while busy is ignored.
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t     state, state_nx;
    logic [7:0] a_sh, b_sh, res_sh;
    logic       br;
    logic [2:0] cnt;
    logic       d, br_nx, last;
    logic [7:0] res_full;

    always_comb begin
        d        = a_sh[0] ^ b_sh[0] ^ br;
        br_nx    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        last     = (cnt == 3'd7);
        res_full = {d, res_sh[7:1]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= 8'h00;
            b_sh   <= 8'h00;
            res_sh <= 8'h00;
            br     <= 1'b0;
            cnt    <= 3'd0;
            done   <= 1'b0;
            Resta  <= 8'h00;
            Bout   <= 1'b0;
            Zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        br     <= Bin;
                        res_sh <= 8'h00;
                        cnt    <= 3'd0;
                    end
                end
                RUN: begin
                    a_sh   <= {1'b0, a_sh[7:1]};
                    b_sh   <= {1'b0, b_sh[7:1]};
                    res_sh <= res_full;
                    br     <= br_nx;
                    cnt    <= cnt + 3'd1;
                    if (last) begin
                        done <= 1'b1;
                        Bout <= br_nx;
`ifdef RESTA_SAT_EN
                        Resta <= br_nx ? 8'h00 : res_full;
                        Zero  <= br_nx | (res_full == 8'h00);
`else
                        Resta <= res_full;
                        Zero  <= (res_full == 8'h00);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign state_dbg = state;

endmodule

// File: tb/tb_restador_serial_8bits.sv
// Scoreboard bench for restador_serial_8bits: directed cases plus 1000 random operations.
module tb_restador_serial_8bits;

    logic       clk, rst, start, Bin;
    logic [7:0] A, B;
    logic       busy, done, Bout, Zero, state_dbg;
    logic [7:0] Resta;

    logic [9:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    restador_serial_8bits dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
        .busy(busy), .done(done), .Resta(Resta), .Bout(Bout), .Zero(Zero),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {Bout, Zero, Resta} from plain 9-bit unsigned arithmetic
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int diff;
        logic bo;
        logic [7:0] r;
        diff = int'(a) - int'(b) - int'(bin);
        bo   = (diff < 0);
        r    = 8'((diff + 256) % 256);
`ifdef RESTA_SAT_EN
        if (bo) r = 8'h00;
`endif
        return {bo, (r == 8'h00), r};
    endfunction

    // Monitor: pops on every done pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) check("busy_done_overlap", 1, 0);
            if (done) begin
                if (exp_q.size() == 0) check("unexpected_done", 1, 0);
                else check("result", {Bout, Zero, Resta}, exp_q.pop_front());
            end
        end
    end

    // Drivers
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit push);
        start = 1'b1; A = a; B = b; Bin = bin;
        @(posedge clk);
        if (push) exp_q.push_back(model(a, b, bin));
        #1;
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
    endtask

    task automatic wait_done(input int edges);
        int n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        if (!done) check("done_timeout", 0, 1);
        else check("latency", n, edges);
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic bin);
        issue(a, b, bin, 1'b1);
        wait_done(8);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; Bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out", {Bout, Zero, Resta}, 10'h000);
        rst = 1'b0;
        @(posedge clk); #1;

        op(8'h50, 8'h20, 1'b0);
        op(8'h20, 8'h50, 1'b0);
        op(8'h00, 8'h00, 1'b1);
        op(8'h7F, 8'h7F, 1'b0);
        op(8'hFF, 8'h00, 1'b0);
        op(8'h00, 8'hFF, 1'b1);

        // start pulses while busy must be ignored; then back-to-back in done cycle
        issue(8'h9C, 8'h35, 1'b1, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            start = (k == 2 || k == 5);
            A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_done(1);
        op(8'hFF, 8'h01, 1'b0);
        check("b2b_resta", Resta, 8'hFE);

        // reset in the 4th RUN cycle
        @(posedge clk); #1;
        issue(8'hA5, 8'h3C, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out", {Bout, Zero, Resta}, 10'h000);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) check("done_after_reset", done, 0);
        end
        check("idle_after_reset", busy, 0);
        op(8'h10, 8'h01, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
